// File: rtl/eqed_inject_ctrl.sv
// eqed_inject_ctrl: single bit-flip injection controller for EQED runs.
// A run lasts `window` cycles. During the run the block compresses misr_in
// into a MISR signature, and it can issue at most one one-hot flip to the
// DUT muxes, at a chosen cycle offset.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start, abort    begin a run (IDLE only); cancel a run (RUN only)
//   inj_en/sel/cyc  injection enable, target flop index, RUN offset
//   window          RUN length in cycles (0 goes straight to DONE)
//   misr_in         data compressed on every RUN cycle
//   flip            one-hot flip select (combinational)
//   busy/done       state is RUN / one-cycle end-of-run pulse
//   injected        sticky: a flip was issued during this run
//   cycle           current RUN offset
//   signature       MISR value
module eqed_inject_ctrl #(
    parameter int                NUM_FF = 8,
    parameter int                SEL_W  = 4,
    parameter int                MISR_W = 6,
    parameter int                IN_W   = 2,
    parameter logic [MISR_W-1:0] TAPS   = 6'b110000,
    parameter logic [MISR_W-1:0] SEED   = 6'b000001,
    parameter int                WIN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              inj_en,
    input  logic [SEL_W-1:0]  inj_sel,
    input  logic [WIN_W-1:0]  inj_cycle,
    input  logic [WIN_W-1:0]  window,
    input  logic [IN_W-1:0]   misr_in,
    output logic [NUM_FF-1:0] flip,
    output logic              busy,
    output logic              done,
    output logic              injected,
    output logic [WIN_W-1:0]  cycle,
    output logic [MISR_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [WIN_W-1:0]    icyc_q, icyc_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [WIN_W-1:0]    cycle_q, cycle_d;
    logic [MISR_W-1:0]   sig_q, sig_d;
    logic                inj_q, inj_d;
    logic                busy_q;
    logic                done_q;

    logic                sel_ok;
    logic                fire;
    logic                fb;
    logic [MISR_W-1:0]   sig_step;
    logic                last;

    // An out-of-range select never fires. An out-of-range inject cycle
    // never matches, because cycle stays below the window while in RUN.
    assign sel_ok = (int'(sel_q) < NUM_FF);

    assign fire = (state_q == RUN) && en_q && !inj_q && !abort
                  && (cycle_q == icyc_q) && sel_ok;

    assign flip = fire ? (NUM_FF'(1) << sel_q) : '0;

    assign fb       = ^(sig_q & TAPS);
    assign sig_step = {sig_q[MISR_W-2:0], fb} ^ MISR_W'(misr_in);

    // win_q is never zero in RUN, so the subtraction cannot wrap.
    assign last = (cycle_q == (win_q - 1'b1));

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        sel_d   = sel_q;
        icyc_d  = icyc_q;
        win_d   = win_q;
        cycle_d = cycle_q;
        sig_d   = sig_q;
        inj_d   = inj_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    en_d    = inj_en;
                    sel_d   = inj_sel;
                    icyc_d  = inj_cycle;
                    win_d   = window;
                    cycle_d = '0;
                    sig_d   = SEED;
                    inj_d   = 1'b0;
                    state_d = (window == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort freezes signature, cycle and the injected flag.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sig_d   = sig_step;
                    cycle_d = cycle_q + 1'b1;
                    if (fire) begin
                        inj_d = 1'b1;
                    end
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            sel_q   <= '0;
            icyc_q  <= '0;
            win_q   <= '0;
            cycle_q <= '0;
            sig_q   <= SEED;
            inj_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            icyc_q  <= icyc_d;
            win_q   <= win_d;
            cycle_q <= cycle_d;
            sig_q   <= sig_d;
            inj_q   <= inj_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign injected  = inj_q;
    assign cycle     = cycle_q;
    assign signature = sig_q;

endmodule
